// File: rtl/trv_frontend.sv
// ----------------------------------------------------------------------------
// trv_frontend
//
// Slot manager in front of a ray-traversal engine. Incoming init requests are
// given a free slot from a free-slot FIFO. The {cid,tid} tag is parked in a
// per-slot tag table, and the ray is forwarded to the engine as {ray, slot}.
// Engine completions {result, slot} are joined with the parked tag and
// returned as {result, cid, tid} through a single holding register. The slot
// is then recycled into the free FIFO.
//
// Optional feature macro: SLOT_ERR_CHECK_EN
//   defined   - a completion for a slot that is not busy is consumed and
//               dropped, and it raises the sticky slot_err flag.
//   undefined - slot_err is tied low and every completion is treated as legal.
//
// Field widths come from the RAY/CID/TID/RESULT width macros below. Each
// macro can be overridden before this file is compiled.
// ----------------------------------------------------------------------------
`default_nettype none

`ifndef RAY_WIDTH
`define RAY_WIDTH 16
`endif
`ifndef CID_WIDTH
`define CID_WIDTH 4
`endif
`ifndef TID_WIDTH
`define TID_WIDTH 4
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 8
`endif
`ifndef INIT_REQ_WIDTH
`define INIT_REQ_WIDTH (`RAY_WIDTH + `CID_WIDTH + `TID_WIDTH)
`endif
`ifndef TRV_RESP_WIDTH
`define TRV_RESP_WIDTH (`RESULT_WIDTH + `CID_WIDTH + `TID_WIDTH)
`endif

module trv_frontend #(
    parameter int NUM_SLOTS  = 8,
    parameter int SLOT_WIDTH = 3
) (
    input  logic                                clk,
    input  logic                                arst_n,

    input  logic                                init_req_stream_empty_n,
    output logic                                init_req_stream_read,
    input  logic [`INIT_REQ_WIDTH-1:0]          init_req_stream_dout,

    input  logic                                job_stream_full_n,
    output logic                                job_stream_write,
    output logic [`RAY_WIDTH+SLOT_WIDTH-1:0]    job_stream_din,

    input  logic                                done_stream_empty_n,
    output logic                                done_stream_read,
    input  logic [`RESULT_WIDTH+SLOT_WIDTH-1:0] done_stream_dout,

    input  logic                                trv_resp_stream_full_n,
    output logic                                trv_resp_stream_write,
    output logic [`TRV_RESP_WIDTH-1:0]          trv_resp_stream_din,

    output logic [SLOT_WIDTH:0]                 in_flight,
    output logic                                slot_err
);

    localparam int                    TAG_WIDTH = `CID_WIDTH + `TID_WIDTH;
    localparam logic [SLOT_WIDTH:0]   FREE_FULL = (SLOT_WIDTH+1)'(NUM_SLOTS);
    localparam logic [SLOT_WIDTH-1:0] LAST_IDX  = SLOT_WIDTH'(NUM_SLOTS - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e                    state_q, state_d;
    logic [SLOT_WIDTH-1:0]     init_cnt_q, init_cnt_d;

    logic [SLOT_WIDTH-1:0]     free_mem [NUM_SLOTS];
    logic [SLOT_WIDTH-1:0]     rd_ptr_q, rd_ptr_d;
    logic [SLOT_WIDTH-1:0]     wr_ptr_q, wr_ptr_d;
    logic [SLOT_WIDTH:0]       free_cnt_q, free_cnt_d;

    logic [TAG_WIDTH-1:0]      tag_mem [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]      busy_q, busy_d;
    logic [SLOT_WIDTH:0]       in_flight_q, in_flight_d;

    logic                      out_valid_q, out_valid_d;
    logic [`TRV_RESP_WIDTH-1:0] out_data_q, out_data_d;

    // ------------------------------------------------------------------------
    // Field decode
    // ------------------------------------------------------------------------
    logic [`RAY_WIDTH-1:0]     req_ray;
    logic [TAG_WIDTH-1:0]      req_tag;
    logic [SLOT_WIDTH-1:0]     done_slot;
    logic [`RESULT_WIDTH-1:0]  done_result;
    logic [SLOT_WIDTH-1:0]     free_head;

    assign req_ray     = init_req_stream_dout[`INIT_REQ_WIDTH-1 -: `RAY_WIDTH];
    assign req_tag     = init_req_stream_dout[TAG_WIDTH-1:0];
    assign done_slot   = done_stream_dout[SLOT_WIDTH-1:0];
    assign done_result = done_stream_dout[`RESULT_WIDTH+SLOT_WIDTH-1 -: `RESULT_WIDTH];
    assign free_head   = free_mem[rd_ptr_q];

    // ------------------------------------------------------------------------
    // Handshakes (combinational by design; all gated to zero outside RUN)
    // ------------------------------------------------------------------------
    logic run;
    logic accept;        // init request taken and job issued this cycle
    logic resp_fire;     // holding register drained this cycle
    logic done_fire;     // completion consumed this cycle (legal or not)
    logic done_legal;    // completion refers to a slot we consider valid
    logic done_take;     // completion loads the holding register
    logic done_release;  // completion actually retires a busy slot
    logic init_push;
    logic free_push;
    logic [SLOT_WIDTH-1:0] push_slot;

    assign run       = (state_q == ST_RUN);
    assign accept    = run && (free_cnt_q != '0) && init_req_stream_empty_n && job_stream_full_n;
    assign resp_fire = out_valid_q && trv_resp_stream_full_n;
    // Drain-and-refill in one cycle keeps the response path bubble-free.
    assign done_fire = run && done_stream_empty_n && (!out_valid_q || resp_fire);

`ifdef SLOT_ERR_CHECK_EN
    assign done_legal = busy_q[done_slot];
`else
    assign done_legal = 1'b1;
`endif

    assign done_take    = done_fire && done_legal;
    assign done_release = done_take && busy_q[done_slot];

    // A stray completion must never overfill the free FIFO and corrupt its
    // contents, so a push is dropped once every slot is already free.
    assign init_push = (state_q == ST_INIT);
    assign free_push = init_push || (done_take && (free_cnt_q != FREE_FULL));
    assign push_slot = init_push ? init_cnt_q : done_slot;

    assign init_req_stream_read  = accept;
    assign job_stream_write      = accept;
    assign job_stream_din        = {req_ray, free_head};
    assign done_stream_read      = done_fire;
    assign trv_resp_stream_write = resp_fire;
    assign trv_resp_stream_din   = out_data_q;
    assign in_flight             = in_flight_q;

    // ------------------------------------------------------------------------
    // Next-state logic for the init sequencer, free FIFO, slot tracking and
    // the response holding register.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a
        // value unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        free_cnt_d  = free_cnt_q;
        busy_d      = busy_q;
        in_flight_d = in_flight_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;

        // INIT walks the slot indices into the free FIFO, one per cycle.
        if (state_q == ST_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
            if (init_cnt_q == LAST_IDX) begin
                state_d = ST_RUN;
            end
        end

        // Free FIFO pointers and occupancy.
        if (free_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (accept) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({free_push, accept})
            2'b10:   free_cnt_d = free_cnt_q + 1'b1;
            2'b01:   free_cnt_d = free_cnt_q - 1'b1;
            default: free_cnt_d = free_cnt_q;
        endcase

        // An accepted slot comes from the free FIFO, so it is never the busy
        // slot being retired in the same cycle. The two updates cannot collide.
        if (accept) begin
            busy_d[free_head] = 1'b1;
        end
        if (done_release) begin
            busy_d[done_slot] = 1'b0;
        end
        case ({accept, done_release})
            2'b10:   in_flight_d = in_flight_q + 1'b1;
            2'b01:   in_flight_d = in_flight_q - 1'b1;
            default: in_flight_d = in_flight_q;
        endcase

        // Holding register: a new completion wins over a plain drain.
        if (done_take) begin
            out_valid_d = 1'b1;
            out_data_d  = {done_result, tag_mem[done_slot]};
        end else if (resp_fire) begin
            out_valid_d = 1'b0;
        end
    end

    // Control registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge value of every other register.
        if (!arst_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            free_cnt_q  <= '0;
            busy_q      <= '0;
            in_flight_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            free_cnt_q  <= free_cnt_d;
            busy_q      <= busy_d;
            in_flight_q <= in_flight_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Free-slot storage and tag table writes.
    always_ff @(posedge clk) begin
        // NOTE: the storage arrays are deliberately not reset. Pointers,
        // occupancy and busy bits decide which entries are meaningful, and
        // INIT rewrites the whole free FIFO after every reset.
        if (arst_n && free_push) begin
            free_mem[wr_ptr_q] <= push_slot;
        end
        if (arst_n && accept) begin
            tag_mem[free_head] <= req_tag;
        end
    end

`ifdef SLOT_ERR_CHECK_EN
    logic slot_err_q, slot_err_d;

    assign slot_err_d = slot_err_q || (done_fire && !done_legal);
    assign slot_err   = slot_err_q;

    // Sticky illegal-completion flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            slot_err_q <= 1'b0;
        end else begin
            slot_err_q <= slot_err_d;
        end
    end
`else
    assign slot_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/trv_frontend.md
TRV_FRONTEND -- requirements
Module: trv_frontend

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 8, meaning number of in-flight ray slots (power of two, 2..64).
REQ-002 SHALL have parameter SLOT_WIDTH, default 3, meaning slot index width, equal to log2(NUM_SLOTS).
REQ-003 SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port arst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port init_req_stream_empty_n  input  1  init request available.
REQ-006 SHALL have port init_req_stream_read  output  1  init request consumed.
REQ-007 SHALL have port init_req_stream_dout  input  `INIT_REQ_WIDTH  {ray[`RAY_WIDTH], cid[`CID_WIDTH], tid[`TID_WIDTH]}.
REQ-008 SHALL have port job_stream_full_n  input  1  engine can take a job.
REQ-009 SHALL have port job_stream_write  output  1  job issued.
REQ-010 SHALL have port job_stream_din  output  `RAY_WIDTH+SLOT_WIDTH  {ray, slot}.
REQ-011 SHALL have port done_stream_empty_n  input  1  engine completion available.
REQ-012 SHALL have port done_stream_read  output  1  completion consumed.
REQ-013 SHALL have port done_stream_dout  input  `RESULT_WIDTH+SLOT_WIDTH  {result, slot}.
REQ-014 SHALL have port trv_resp_stream_full_n  input  1  response sink has space.
REQ-015 SHALL have port trv_resp_stream_write  output  1  response issued.
REQ-016 SHALL have port trv_resp_stream_din  output  `TRV_RESP_WIDTH  {result, cid, tid}.
REQ-017 SHALL have port in_flight  output  SLOT_WIDTH+1  number of busy slots.
REQ-018 SHALL have port slot_err  output  1  sticky illegal-completion flag.

Function
REQ-019 SHALL hold a free-slot FIFO of depth NUM_SLOTS, a tag table of {cid,tid} per slot, and a busy bit per slot.
REQ-020 SHALL enter INIT after reset, pushing slot indices 0..NUM_SLOTS-1 into the free FIFO one per cycle, then move to RUN after NUM_SLOTS cycles; RUN persists until reset.
REQ-021 SHALL assert init_req_stream_read = RUN && free FIFO nonempty && init_req_stream_empty_n && job_stream_full_n, combinationally.
REQ-022 SHALL assert job_stream_write equal to init_req_stream_read, with job_stream_din = {ray, free FIFO head}.
REQ-023 SHALL, on accepting an init request, pop the free FIFO, write tag[slot] = {cid,tid}, and set busy[slot] at the next edge.
REQ-024 SHALL assert trv_resp_stream_write = out_valid && trv_resp_stream_full_n, where out_valid is a registered holding bit.
REQ-025 SHALL assert done_stream_read = done_stream_empty_n && (!out_valid || trv_resp_stream_write), giving full throughput with no bubble.
REQ-026 SHALL, on a legal completion, load the holding register with {result, tag[slot]}, set out_valid, clear busy[slot], and push slot to the free FIFO; done to response latency is 1 cycle.
REQ-027 SHALL clear out_valid after a write when no new completion is loaded that cycle.
REQ-028 SHALL emit responses in completion order, not request order.
REQ-029 SHALL not make a slot freed in cycle N poppable before cycle N+1.
REQ-030 SHALL allow an accept and a completion in the same cycle; in_flight is then unchanged.
REQ-031 SHALL keep in_flight = popcount(busy), updated +1 on accept, -1 on completion, range 0..NUM_SLOTS.
REQ-032 SHALL stop accepting requests when in_flight = NUM_SLOTS, because the free FIFO is then empty.

Reset
REQ-033 SHALL, while arst_n is low at a clock edge, clear all busy bits, empty the free FIFO, clear out_valid, clear slot_err, and enter INIT.
REQ-034 SHALL hold all handshake outputs (init_req_stream_read, job_stream_write, done_stream_read, trv_resp_stream_write) at 0, and in_flight at 0, during reset and INIT.
REQ-035 SHALL discard all in-flight state on a reset asserted mid-operation; the environment must also flush the engine.

Configuration
REQ-036 SHALL, with SLOT_ERR_CHECK_EN defined, treat a completion whose slot is not busy as illegal: consume it, set slot_err sticky, emit no response, and push no slot to the free FIFO.
REQ-037 SHALL, without SLOT_ERR_CHECK_EN, tie slot_err to 0 and treat every completion as legal.

Verification
REQ-038 Reset then idle: after 8 cycles in_flight=0, no reads or writes; the first request is accepted on cycle 9 with job slot 0.
REQ-039 Fill: 9 requests with job_stream_full_n=1; 8 are accepted with slots 0..7, in_flight=8, and the 9th stalls until one completion.
REQ-040 Out-of-order: request cid=2,tid=1 gets slot 0 and cid=5,tid=1 gets slot 1; complete slot 1 with result=0xA, then slot 0 with result=0xB; responses are {0xA,5,1} then {0xB,2,1}, each 1 cycle after its done.
REQ-041 Backpressure: trv_resp_stream_full_n=0 with 2 pending completions; exactly 1 is consumed and the output is held stable; on release, back-to-back writes occur with no bubble.
REQ-042 Simultaneous events: an accept and a completion in the same cycle leave in_flight constant, and the freed slot is reused no earlier than the next cycle.
REQ-043 Illegal completion: with SLOT_ERR_CHECK_EN defined, a done for idle slot 3 gives slot_err=1, no response, and in_flight unchanged; without the macro a response is emitted.
